// File: rtl/mem_arbiter_if.sv
// Bundle for the two-requester memory arbiter: fetch (m0) and LSU (m1) request
// ports plus the single shared memory port.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            m0_r_v;
  logic            m0_w_v;
  logic [XLEN-1:0] m0_adr;
  logic [XLEN-1:0] m0_data;
  logic [3:0]      m0_strobe;
  logic            m0_ack;
  logic            m0_res_v;
  logic [XLEN-1:0] m0_res;
  logic            m0_err;

  logic            m1_r_v;
  logic            m1_w_v;
  logic [XLEN-1:0] m1_adr;
  logic [XLEN-1:0] m1_data;
  logic [3:0]      m1_strobe;
  logic            m1_ack;
  logic            m1_res_v;
  logic [XLEN-1:0] m1_res;
  logic            m1_err;

  logic            mem_r_v;
  logic            mem_w_v;
  logic [XLEN-1:0] mem_adr;
  logic [XLEN-1:0] mem_data;
  logic [3:0]      mem_strobe;
  logic            mem_hit;
  logic [XLEN-1:0] mem_res;
  logic            mem_error;

  // Arbiter side: accepts requests, drives the shared memory port.
  modport slave (
    input  m0_r_v, m0_w_v, m0_adr, m0_data, m0_strobe,
    output m0_ack, m0_res_v, m0_res, m0_err,
    input  m1_r_v, m1_w_v, m1_adr, m1_data, m1_strobe,
    output m1_ack, m1_res_v, m1_res, m1_err,
    output mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe,
    input  mem_hit, mem_res, mem_error
  );

  // Environment side: requesters and memory.
  modport master (
    output m0_r_v, m0_w_v, m0_adr, m0_data, m0_strobe,
    input  m0_ack, m0_res_v, m0_res, m0_err,
    output m1_r_v, m1_w_v, m1_adr, m1_data, m1_strobe,
    input  m1_ack, m1_res_v, m1_res, m1_err,
    input  mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe,
    output mem_hit, mem_res, mem_error
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter onto a single memory port; one transaction in
// flight, with a hit timeout that returns an error response to the owner.
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last_grant;
  logic [CNT_W-1:0] cnt;
  logic            owner;
  logic            op_wr;
  logic [XLEN-1:0] lat_adr;
  logic [XLEN-1:0] lat_data;
  logic [3:0]      lat_strobe;

  logic            req0;
  logic            req1;
  logic            grant0;
  logic            grant1;
  logic            grant;
  logic            cnt_last;
  logic            done_ok;
  logic            done_to;
  logic            resp;
  logic [XLEN-1:0] rdata;
  logic            rerr;

  logic            res_v0_q;
  logic            res_v1_q;
  logic [XLEN-1:0] res0_q;
  logic [XLEN-1:0] res1_q;
  logic            err0_q;
  logic            err1_q;

  assign req0     = bus.m0_r_v | bus.m0_w_v;
  assign req1     = bus.m1_r_v | bus.m1_w_v;
  assign grant    = grant0 | grant1;
  assign cnt_last = (cnt == CNT_W'(TIMEOUT - 1));

  // last_grant holds the index of the port served most recently, so the other
  // port wins the next contention.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: begin
        grant0 = req0 && (!req1 || last_grant);
        grant1 = req1 && (!req0 || !last_grant);
        if (grant0 || grant1) state_nxt = BUSY;
      end
      BUSY: begin
        if (bus.mem_hit) begin
          done_ok   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_last) begin
          done_to   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign resp  = done_ok | done_to;
  assign rdata = (done_ok && !op_wr) ? bus.mem_res : '0;
  assign rerr  = done_ok ? bus.mem_error : done_to;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      owner      <= 1'b0;
      op_wr      <= 1'b0;
      lat_adr    <= '0;
      lat_data   <= '0;
      lat_strobe <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last_grant <= grant1;
        owner      <= grant1;
        op_wr      <= grant1 ? bus.m1_w_v      : bus.m0_w_v;
        lat_adr    <= grant1 ? bus.m1_adr      : bus.m0_adr;
        lat_data   <= grant1 ? bus.m1_data     : bus.m0_data;
        lat_strobe <= grant1 ? bus.m1_strobe   : bus.m0_strobe;
        cnt        <= '0;
      end else if (state == BUSY && !bus.mem_hit) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Response stage: one-cycle pulse to the owner, everything else forced to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_v0_q <= 1'b0;
      res_v1_q <= 1'b0;
      res0_q   <= '0;
      res1_q   <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      res_v0_q <= resp && !owner;
      res_v1_q <= resp && owner;
      res0_q   <= (resp && !owner) ? rdata : '0;
      res1_q   <= (resp && owner)  ? rdata : '0;
      err0_q   <= resp && !owner && rerr;
      err1_q   <= resp && owner && rerr;
    end
  end

  assign bus.m0_ack     = grant0;
  assign bus.m1_ack     = grant1;
  assign bus.m0_res_v   = res_v0_q;
  assign bus.m1_res_v   = res_v1_q;
  assign bus.m0_res     = res0_q;
  assign bus.m1_res     = res1_q;
  assign bus.m0_err     = err0_q;
  assign bus.m1_err     = err1_q;

  assign bus.mem_r_v    = (state == BUSY) && !op_wr;
  assign bus.mem_w_v    = (state == BUSY) && op_wr;
  assign bus.mem_adr    = (state == BUSY) ? lat_adr    : '0;
  assign bus.mem_data   = (state == BUSY) ? lat_data   : '0;
  assign bus.mem_strobe = (state == BUSY) ? lat_strobe : '0;

endmodule
